// File: rtl/imm_decode_stage_pkg.sv
// Shared RV32 decode types: immediate format enum, opcode map, per-entry metadata.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_decode_stage_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_NONE = 3'd7
    } imm_fmt_t;

    // Base opcodes, also consumed by the control FSM
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        imm_fmt_t    fmt;
        logic [11:0] csr_addr;
        logic        illegal;
    } imm_meta_t;

    localparam imm_meta_t META_RESET = '{fmt: FMT_NONE, csr_addr: 12'h000, illegal: 1'b0};

    function automatic bit imm_xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode_stage_extract.sv
// Combinational RV32 immediate extractor: I/S/B/U/J sign-extend, CSR zimm/address.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter bit              CSR_EN        = 1'b1,
    parameter logic [XLEN-1:0] ILLEGAL_VALUE = {XLEN{1'b1}}
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_fmt,
    output logic [11:0]     csr_addr,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    imm_fmt_t    fmt;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    always_comb begin
        imm32     = 32'h0;
        fmt       = FMT_NONE;
        csr_addr  = 12'h000;
        illegal   = 1'b0;
        immediate = '0;
        unique case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{instruction[31]}}, instruction[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instruction[31:12], 12'h000};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
            end
            OPC_OP, OPC_MISC_MEM: fmt = FMT_NONE;
            OPC_SYSTEM: begin
                if (funct3 != 3'b000) begin
                    if (CSR_EN) begin
                        fmt      = FMT_Z;
                        csr_addr = instruction[31:20];
                        // Only the *I forms carry a zimm; register forms read rs1 instead
                        if (funct3[2]) imm32 = {27'h0, instruction[19:15]};
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            default: illegal = 1'b1;
        endcase

        if (instruction[1:0] != 2'b11) illegal = 1'b1;

        if (illegal) begin
            fmt       = FMT_NONE;
            csr_addr  = 12'h000;
            immediate = ILLEGAL_VALUE;
        end else begin
            immediate       = {XLEN{imm32[31]}};
            immediate[31:0] = imm32;
        end
    end

    assign imm_fmt = fmt;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with valid/ready, optional 2-entry skid buffer, flush.
// Latency: 1 cycle from accept to out_valid; 1 entry/cycle throughput with out_ready high.
// Backpressure: SKID=1 in_ready from registered count only; SKID=0 in_ready = !out_valid | out_ready.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter bit              SKID          = 1'b1,
    parameter bit              CSR_EN        = 1'b1,
    parameter logic [XLEN-1:0] ILLEGAL_VALUE = {XLEN{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_fmt,
    output logic [11:0]     csr_addr,
    output logic            illegal
);

    if (!imm_xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_meta_t       meta;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{imm: '0, meta: META_RESET};

    entry_t     dec_dat;
    entry_t     slot0;
    entry_t     slot1;
    logic [2:0] dec_fmt;
    logic [1:0] count;
    logic       push;
    logic       pop;

    imm_extract #(
        .XLEN          (XLEN),
        .CSR_EN        (CSR_EN),
        .ILLEGAL_VALUE (ILLEGAL_VALUE)
    ) u_extract (
        .instruction (instruction),
        .immediate   (dec_dat.imm),
        .imm_fmt     (dec_fmt),
        .csr_addr    (dec_dat.meta.csr_addr),
        .illegal     (dec_dat.meta.illegal)
    );

    assign dec_dat.meta.fmt = imm_fmt_t'(dec_fmt);

    if (SKID) begin : g_skid
        assign in_ready = (count < 2'd2);
    end else begin : g_single
        assign in_ready = !out_valid || out_ready;
    end

    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // slot0 is always the head and drives the outputs directly; slot1 only fills when SKID=1
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
            slot0 <= ENTRY_RESET;
            slot1 <= ENTRY_RESET;
        end else begin
            if (pop && count == 2'd2) slot0 <= slot1;
            if (push) begin
                if (count == 2'd0 || (pop && count == 2'd1)) slot0 <= dec_dat;
                else                                          slot1 <= dec_dat;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign immediate = slot0.imm;
    assign imm_fmt   = slot0.meta.fmt;
    assign csr_addr  = slot0.meta.csr_addr;
    assign illegal   = slot0.meta.illegal;

endmodule
